frac_divider: RTL and testbench
===============================

Name: frac_divider

Overview:
- Sequential restoring divider producing the fractional quotient dividend/divider as an unsigned Q0.8 value, one quotient bit per clock.
- Stepped by an externally supplied cycle counter (0..7) from the surrounding control FSM.
- frac_val is complete after the clock edge sampled with cycle_cnt==7.
- Used to compute ratios with numerator < denominator, e.g. 1/27 -> 0x09.

Parameters:
- DW, 7, width of dividend and divider operands.
- FW, 8, fraction width (number of quotient bits / steps).
- CW, 3, width of cycle_cnt; must satisfy 2^CW >= FW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cycle_cnt  input  CW  step index; 0 starts a new division, k computes quotient bit FW-1-k.
- divider  input  DW  denominator, unsigned.
- dividend  input  DW  numerator, unsigned; expected < divider.
- frac_val  output  FW  registered Q0.FW quotient, truncated (floor(dividend*2^FW/divider)).

Behaviour:
- Reset (rst==0, async): frac_val=0, internal remainder rem (DW+1 bits)=0, active=0, sat=0. Reset mid-division aborts it; the next division starts only at cycle_cnt==0 after release.
- Step datapath (combinational, per clock):
  - src = (cycle_cnt==0) ? dividend : rem.
  - t = src<<1, DW+1 bits, no overflow.
  - If t >= divider: bit=1, rem_next=t-divider; else bit=0, rem_next=t.
- Edge with cycle_cnt==0:
  - Loads rem=rem_next and active=1.
  - frac_val cleared, then bit FW-1 set to the step bit.
  - sat=1 if divider==0 or dividend>=divider.
- Edge with 1<=cycle_cnt<=FW-1 and active==1: rem=rem_next; frac_val[FW-1-cycle_cnt]=bit; other bits hold.
- Edge with cycle_cnt==FW-1: additionally clears active. frac_val then holds until the next cycle_cnt==0 edge.
- Edges with cycle_cnt!=0 while active==0 are ignored; all state holds. Repeated cnt 7, or idle counters, cannot corrupt the result.
- cycle_cnt values >= FW are ignored.
- Saturation: when sat==1, the final result (visible after the cnt FW-1 edge) is all ones (0xFF). Division by zero and improper fractions never wrap.
- Latency: result valid one clock after the edge sampling cnt FW-1, i.e. FW clock edges after starting at cnt 0.
- Operands must be held stable for the whole 0..FW-1 sequence; changes mid-sequence give undefined quotient bits but no lockup.
- Restart: cycle_cnt==0 at any time, including mid-division, aborts the current division and starts fresh.

Optional Feature:
- Macro DIVIDER_DONE_EN.
- When defined: adds output port done (1 bit). done is registered high for exactly one clock after the edge that processed cycle_cnt==FW-1 while active. It is 0 at reset and 0 otherwise.
- When not defined: no done port; behaviour otherwise identical.

Test Plan:
- rst=0 for 2 cycles, then release; cnt stepped 0..7 with dividend=1, divider=27 -> frac_val=0x09 after eighth edge.
- dividend=1, divider=2, cnt 0..7 -> 0x80. Dividend=26, divider=27 -> 0xF6 (floor(26*256/27)=246).
- divider=0, and separately dividend=27 with divider=27, cnt 0..7 -> 0xFF in both cases.
- After completion hold cycle_cnt=7 for 5 edges -> frac_val stays 0x09. Restart at cnt 0 with dividend=3, divider=4 -> 0xC0.
- Assert rst low at cnt=4 mid-division -> frac_val=0 immediately (async). Cnt 5..7 after release ignored, frac_val stays 0.
- With DIVIDER_DONE_EN: done pulses high exactly one clock after the cnt 7 edge, and does not repeat while cnt stays 7.

Source files
------------

// File: rtl/frac_divider.sv
// Restoring fractional divider: dividend/divider as an unsigned Q0.FW value, one bit per clock.
// Optional macro DIVIDER_DONE_EN adds a one-clock 'done' pulse after the final step.
module frac_divider #(
  parameter int DW = 7,
  parameter int FW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cycle_cnt,
  input  logic [DW-1:0] divider,
  input  logic [DW-1:0] dividend,
  output logic [FW-1:0] frac_val
`ifdef DIVIDER_DONE_EN
  ,
  output logic          done
`endif
);

  logic [DW:0]   rem;
  logic [DW:0]   src;
  logic [DW:0]   t;
  logic [DW:0]   rem_next;
  logic [DW:0]   div_ext;
  logic          step_bit;
  logic          active;
  logic          sat;
  logic          start;
  logic          step_en;
  logic          last;
  logic [FW-1:0] frac_next;

  assign div_ext = {1'b0, divider};
  assign start   = (cycle_cnt == '0);
  // Counter values at or beyond FW never advance the division.
  assign step_en = !start && active && (int'(cycle_cnt) < FW);
  assign last    = step_en && (int'(cycle_cnt) == FW - 1);

  // One restoring step: shift the partial remainder, subtract if it fits.
  always_comb begin
    src      = start ? {1'b0, dividend} : rem;
    t        = src << 1;
    step_bit = (t >= div_ext);
    rem_next = step_bit ? (t - div_ext) : t;
  end

  always_comb begin
    frac_next = frac_val;
    if (start) begin
      frac_next         = '0;
      frac_next[FW-1]   = step_bit;
    end else if (step_en) begin
      for (int i = 0; i < FW; i++) begin
        if (i == FW - 1 - int'(cycle_cnt)) frac_next[i] = step_bit;
      end
      // Division by zero or an improper fraction clamps to all ones.
      if (last && sat) frac_next = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      active   <= 1'b0;
      sat      <= 1'b0;
      frac_val <= '0;
    end else begin
      frac_val <= frac_next;
      if (start) begin
        rem    <= rem_next;
        active <= 1'b1;
        sat    <= (divider == '0) || (dividend >= divider);
      end else if (step_en) begin
        rem <= rem_next;
        if (last) active <= 1'b0;
      end
    end
  end

`ifdef DIVIDER_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= last;
    end
  end
`endif

endmodule

// File: tb/tb_frac_divider.sv
// Directed bench for frac_divider: arithmetic reference model checked every cycle plus literal results.
module tb_frac_divider;

  localparam int DW = 7;
  localparam int FW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] cycle_cnt = '1;
  logic [DW-1:0] divider = 7'd1;
  logic [DW-1:0] dividend = 7'd0;
  logic [FW-1:0] frac_val;
`ifdef DIVIDER_DONE_EN
  logic          done;
`endif

  int errors = 0;
  int checks = 0;

  frac_divider #(.DW(DW), .FW(FW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cycle_cnt (cycle_cnt),
    .divider   (divider),
    .dividend  (dividend),
    .frac_val  (frac_val)
`ifdef DIVIDER_DONE_EN
    ,
    .done      (done)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: quotient prefix from integer arithmetic
  logic [FW-1:0] m_frac   = '0;
  logic          m_active = 1'b0;
  logic          m_known  = 1'b1;
  logic          m_done   = 1'b0;
  logic          m_sat    = 1'b0;
  int            m_num    = 0;
  int            m_den    = 1;

  task automatic model_step(input int k);
    if (m_sat) begin
      m_known = (k == FW - 1);
      if (k == FW - 1) m_frac = '1;
    end else begin
      m_known = 1'b1;
      m_frac  = FW'(((m_num << (k + 1)) / m_den) << (FW - 1 - k));
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_frac   = '0;
      m_active = 1'b0;
      m_known  = 1'b1;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (cycle_cnt == 0) begin
        m_num    = int'(dividend);
        m_den    = int'(divider);
        m_sat    = (divider == 0) || (dividend >= divider);
        m_active = 1'b1;
        model_step(0);
      end else if (m_active && int'(cycle_cnt) < FW) begin
        model_step(int'(cycle_cnt));
        if (int'(cycle_cnt) == FW - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (m_known) check("frac_cycle", 32'(frac_val), 32'(m_frac));
`ifdef DIVIDER_DONE_EN
    check("done_cycle", 32'(done), 32'(m_done));
`endif
  end

  // driver: one cycle_cnt value per clock, starting from a falling edge
  task automatic run_div(input int num, input int den, input int first, input int steps);
    dividend = DW'(num);
    divider  = DW'(den);
    for (int k = first; k < first + steps; k++) begin
      cycle_cnt = CW'(k);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_frac", 32'(frac_val), 32'h00);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cnt7_ignored", 32'(frac_val), 32'h00);

    run_div(1, 27, 0, 8);
    check("div_1_27", 32'(frac_val), 32'h09);
`ifdef DIVIDER_DONE_EN
    check("done_pulse", 32'(done), 32'h1);
`endif
    cycle_cnt = 3'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_cnt7", 32'(frac_val), 32'h09);
`ifdef DIVIDER_DONE_EN
      check("done_no_repeat", 32'(done), 32'h0);
`endif
    end

    run_div(1, 2, 0, 8);
    check("div_1_2", 32'(frac_val), 32'h80);
    run_div(26, 27, 0, 8);
    check("div_26_27", 32'(frac_val), 32'hF6);
    run_div(5, 0, 0, 8);
    check("div_by_zero", 32'(frac_val), 32'hFF);
    run_div(27, 27, 0, 8);
    check("div_equal", 32'(frac_val), 32'hFF);

    // abort a division halfway, then restart
    run_div(1, 2, 0, 4);
    run_div(3, 4, 0, 8);
    check("restart_3_4", 32'(frac_val), 32'hC0);

    // asynchronous reset in the middle of a division
    run_div(1, 27, 0, 5);
    check("pre_reset_prefix", 32'(frac_val), 32'h08);
    #2 rst = 1'b0;
    #1 check("async_reset", 32'(frac_val), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    run_div(1, 27, 5, 3);
    check("post_reset_ignored", 32'(frac_val), 32'h00);
`ifdef DIVIDER_DONE_EN
    check("post_reset_no_done", 32'(done), 32'h0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
